ibex_ex_seq_ctrl: RTL
=====================

Name: ibex_ex_seq_ctrl

Overview:
- Issue/sequencing controller for the execute stage. Accepts one ALU or mult/div operation from ID through a valid/ready handshake and drives the EX enable/select/first-cycle controls.
- Owns the two 34-bit intermediate-value registers used by multi-cycle ops.
- Buffers one result toward writeback and aborts on flush or when a per-op cycle-limit watchdog expires.

Parameters:
- MaxExCycles, 40: maximum EX cycles per op, including the accept cycle, before watchdog abort. Legal range 2..255.
- RV32MEn, 1: when 0, mult/div kinds are treated as ALU and mult/div controls are tied 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- issue_valid_i  in  1  ID presents an op
- issue_ready_o  out  1  controller accepts the op this cycle
- issue_kind_i  in  2  0=ALU, 1=MULT, 2=DIV, 3=reserved (treated as ALU)
- flush_i  in  1  kill the in-flight op and any buffered result
- ex_busy_o  out  1  ID must hold operands stable
- alu_instr_first_cycle_o  out  1  to EX
- mult_en_o, div_en_o, mult_sel_o, div_sel_o  out  1 each  to EX
- multdiv_ready_id_o  out  1  to EX
- ex_valid_i  in  1  EX result valid
- result_ex_i  in  32  EX result
- imd_val_we_i  in  2  from EX
- imd_val_d_i  in  68  from EX, two 34-bit slots
- imd_val_q_o  out  68  to EX
- wb_valid_o  out  1  buffered result valid
- wb_ready_i  in  1  writeback consumes
- wb_result_o  out  32  buffered result
- ex_err_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values: state=IDLE; all outputs 0 except issue_ready_o=1; imd registers 0, counter 0, result buffer 0.
- States are IDLE, EXEC and RESP. kind_q holds the latched kind.
- issue_ready_o = IDLE | (RESP & wb_ready_i). It is held 0 while flush_i=1.
- Accept cycle (handshake) is EX cycle 1. This cycle:
  - alu_instr_first_cycle_o=1.
  - Controls are decoded combinationally from issue_kind_i: MULT gives mult_en_o=mult_sel_o=1; DIV gives div_en_o=div_sel_o=1.
  - kind_q is loaded and the counter is set to 1.
- EXEC: controls are decoded from kind_q and alu_instr_first_cycle_o=0. The counter increments each cycle.
- multdiv_ready_id_o=1 in the accept cycle and in EXEC, because the buffer is always free there.
- ex_busy_o=1 in the accept cycle and in EXEC.
- ex_valid_i in the accept cycle or in EXEC:
  - result_ex_i is captured into the buffer.
  - Next state is RESP, with wb_valid_o=1 from the next cycle.
  - Minimum latency from accept to wb_valid_o is 1 cycle.
- No ex_valid_i in the accept cycle: next state is EXEC.
- RESP:
  - wb_valid_o=1 and wb_result_o is stable until wb_ready_i.
  - wb_ready_i without a new issue: next state is IDLE.
  - wb_ready_i with issue_valid_i in the same cycle: the new op is accepted (back-to-back) and the buffer is overwritten only by the new op's ex_valid_i.
- imd registers: slot i (bits 34i+33:34i) loads imd_val_d_i slot when imd_val_we_i[i]=1. This applies only in the accept cycle or EXEC; otherwise we is ignored and the registers hold. imd_val_q_o is the register output, with no bypass.
- Watchdog: if the counter equals MaxExCycles in EXEC and ex_valid_i=0, then:
  - controls drop the next cycle;
  - ex_err_o pulses for 1 cycle;
  - next state is IDLE and no result is produced.
- ex_valid_i on the watchdog cycle wins: the result is captured and there is no error.
- flush_i (any state) has priority over everything except reset:
  - next state is IDLE, and wb_valid_o is 0 the next cycle;
  - enables and sels are forced 0 combinationally in that cycle;
  - no accept and no imd write;
  - ex_err_o stays 0.
- RV32MEn=0: MULT and DIV run as ALU.
- Asynchronous reset mid-op: immediate return to reset values.

Decomposition:
- Shared package holds the issue-kind enum (EX_KIND_ALU/MULT/DIV) and the FSM state enum.
- Sub-module ibex_ex_result_buf: 1-entry valid/ready result holding register. Counter and imd registers stay inline.

Test Plan:
- ALU op with ex_valid_i=1 in the accept cycle, result_ex_i=0x0000_1234, wb_ready_i=1 -> wb_valid_o=1 with 0x1234 exactly 1 cycle after accept, then IDLE, and alu_instr_first_cycle_o=1 only in the accept cycle.
- DIV with ex_valid_i on EX cycle 37 -> div_en_o/div_sel_o high for cycles 1..37; imd_val_we_i=2'b11 with 0x3_FFFF_FFFF/0x0_0000_0001 reflected on imd_val_q_o the next cycle; no ex_err_o.
- wb_ready_i=0 for 5 cycles in RESP -> wb_result_o stable, issue_ready_o=0; then wb_ready_i=1 with issue_valid_i=1 (MULT) -> back-to-back accept and mult_en_o=1 in that same cycle.
- MULT with ex_valid_i never asserted, MaxExCycles=40 -> ex_err_o one-cycle pulse after cycle 40, wb_valid_o never 1, IDLE afterwards.
- flush_i in EX cycle 3 of DIV -> div_en_o=0 the same cycle, IDLE next, no wb_valid_o; flush_i in RESP -> wb_valid_o=0 the next cycle.
- rst_ni low mid-EXEC while imd registers are nonzero -> all outputs and imd_val_q_o=0 immediately, issue_ready_o=1.

Source files
------------

// File: rtl/ibex_ex_seq_ctrl_pkg.sv
// Shared types for the execute-stage issue/sequencing controller.
package ibex_ex_seq_ctrl_pkg;

  // Operation kind as presented by ID; encoding 3 is reserved and runs as ALU.
  typedef enum logic [1:0] {
    EX_KIND_ALU  = 2'd0,
    EX_KIND_MULT = 2'd1,
    EX_KIND_DIV  = 2'd2
  } ex_kind_e;

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } ex_state_e;

  localparam int unsigned ImdW = 34;  // width of one intermediate-value slot
  localparam int unsigned CntW = 8;   // EX cycle counter, covers limits up to 255

  // Map the raw ID kind onto what the core can execute; without the M
  // extension every op is sequenced as a plain ALU op.
  function automatic ex_kind_e norm_kind(input logic [1:0] raw, input bit md_en);
    ex_kind_e k;
    k = EX_KIND_ALU;
    if (md_en) begin
      case (raw)
        2'd1:    k = EX_KIND_MULT;
        2'd2:    k = EX_KIND_DIV;
        default: k = EX_KIND_ALU;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/ibex_ex_seq_ctrl_if.sv
// Issue, EX-control and writeback signal bundle of the sequencing controller.
interface ibex_ex_seq_ctrl_if;
  import ibex_ex_seq_ctrl_pkg::*;

  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [1:0]          issue_kind_i;
  logic                flush_i;
  logic                ex_busy_o;
  logic                alu_instr_first_cycle_o;
  logic                mult_en_o;
  logic                div_en_o;
  logic                mult_sel_o;
  logic                div_sel_o;
  logic                multdiv_ready_id_o;
  logic                ex_valid_i;
  logic [31:0]         result_ex_i;
  logic [1:0]          imd_val_we_i;
  logic [2*ImdW-1:0]   imd_val_d_i;
  logic [2*ImdW-1:0]   imd_val_q_o;
  logic                wb_valid_o;
  logic                wb_ready_i;
  logic [31:0]         wb_result_o;
  logic                ex_err_o;

  // Controller side.
  modport slave (
    input  issue_valid_i, issue_kind_i, flush_i, ex_valid_i, result_ex_i,
           imd_val_we_i, imd_val_d_i, wb_ready_i,
    output issue_ready_o, ex_busy_o, alu_instr_first_cycle_o, mult_en_o, div_en_o,
           mult_sel_o, div_sel_o, multdiv_ready_id_o, imd_val_q_o, wb_valid_o,
           wb_result_o, ex_err_o
  );

  // ID / EX / writeback side.
  modport master (
    output issue_valid_i, issue_kind_i, flush_i, ex_valid_i, result_ex_i,
           imd_val_we_i, imd_val_d_i, wb_ready_i,
    input  issue_ready_o, ex_busy_o, alu_instr_first_cycle_o, mult_en_o, div_en_o,
           mult_sel_o, div_sel_o, multdiv_ready_id_o, imd_val_q_o, wb_valid_o,
           wb_result_o, ex_err_o
  );
endinterface

// File: rtl/ibex_ex_result_buf.sv
// One-entry valid/ready holding register for the EX result toward writeback.
module ibex_ex_result_buf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] data_o
);
  logic        valid_q;
  logic [31:0] data_q;

  // Flush drops the entry; a new load wins over a same-cycle consume so a
  // back-to-back op can refill the slot as it drains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush_i)      valid_q <= 1'b0;
      else if (load_i)  valid_q <= 1'b1;
      else if (ready_i) valid_q <= 1'b0;
      if (load_i && !flush_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/ibex_ex_seq_ctrl.sv
// Execute-stage issue/sequencing controller: accepts one op from ID, drives
// EX enables/selects, owns the intermediate-value registers, buffers the
// result and aborts on flush or cycle-limit expiry.
module ibex_ex_seq_ctrl
  import ibex_ex_seq_ctrl_pkg::*;
#(
  parameter int unsigned MaxExCycles = 40,
  parameter bit          RV32MEn     = 1'b1
) (
  input logic               clk_i,
  input logic               rst_ni,
  ibex_ex_seq_ctrl_if.slave bus
);
  ex_state_e            state_q, state_d;
  ex_kind_e             kind_q, kind_cur;
  logic [CntW-1:0]      cnt_q;
  logic [1:0][ImdW-1:0] imd_q;
  logic                 err_q;
  logic                 issue_ready, accept, ex_active, wd_hit;
  logic                 buf_load, buf_pop, buf_valid;
  logic [31:0]          buf_data;

  // Handshake, activity and watchdog qualifiers; flush masks every action.
  always_comb begin
    issue_ready = !bus.flush_i &&
                  (state_q == ST_IDLE || (state_q == ST_RESP && bus.wb_ready_i));
    accept      = bus.issue_valid_i && issue_ready;
    ex_active   = !bus.flush_i && (accept || state_q == ST_EXEC);
    kind_cur    = accept ? norm_kind(bus.issue_kind_i, RV32MEn) : kind_q;
    // cnt_q counts EX cycles already completed, so the current cycle is
    // cnt_q + 1; the op is aborted when that reaches the limit.
    wd_hit      = state_q == ST_EXEC && !bus.flush_i && !bus.ex_valid_i &&
                  cnt_q == CntW'(MaxExCycles - 1);
    buf_load    = ex_active && bus.ex_valid_i;
    buf_pop     = state_q == ST_RESP && bus.wb_ready_i;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned
    // and no latch is inferred.
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = bus.ex_valid_i ? ST_RESP : ST_EXEC;
        ST_EXEC: begin
          if (bus.ex_valid_i) state_d = ST_RESP;
          else if (wd_hit)    state_d = ST_IDLE;
        end
        ST_RESP: begin
          if (bus.wb_ready_i) begin
            if (!accept)             state_d = ST_IDLE;
            else if (bus.ex_valid_i) state_d = ST_RESP;
            else                     state_d = ST_EXEC;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state, latched kind, EX cycle counter and registered abort pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      kind_q  <= EX_KIND_ALU;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= wd_hit;
      if (accept) begin
        kind_q <= kind_cur;
        cnt_q  <= CntW'(1);
      end else if (state_q == ST_EXEC && !bus.flush_i) begin
        cnt_q  <= cnt_q + CntW'(1);
      end
    end
  end

  // Intermediate-value slots, written by EX only while an op is executing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: these registers are reset explicitly because EX may read them
    // before its first write; a storage array without reset would show X.
    if (!rst_ni) begin
      imd_q <= '0;
    end else if (ex_active) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.imd_val_we_i[i]) imd_q[i] <= bus.imd_val_d_i[ImdW*i +: ImdW];
      end
    end
  end

  ibex_ex_result_buf u_result_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (bus.flush_i),
    .load_i  (buf_load),
    .data_i  (bus.result_ex_i),
    .ready_i (buf_pop),
    .valid_o (buf_valid),
    .data_o  (buf_data)
  );

  assign bus.issue_ready_o           = issue_ready;
  assign bus.alu_instr_first_cycle_o = accept;
  assign bus.mult_en_o               = ex_active && kind_cur == EX_KIND_MULT;
  assign bus.mult_sel_o              = ex_active && kind_cur == EX_KIND_MULT;
  assign bus.div_en_o                = ex_active && kind_cur == EX_KIND_DIV;
  assign bus.div_sel_o               = ex_active && kind_cur == EX_KIND_DIV;
  assign bus.ex_busy_o               = ex_active;
  assign bus.multdiv_ready_id_o      = ex_active;
  assign bus.imd_val_q_o             = imd_q;
  assign bus.wb_valid_o              = buf_valid;
  assign bus.wb_result_o             = buf_data;
  assign bus.ex_err_o                = err_q;
endmodule
